// File: rtl/signed_bin_to_bcd_seq.sv
// Signed binary to 3-digit BCD, double-dabble, one bit per clock.
// Ports: clk, rst (sync active-low), start, val_in -> busy, done, is_negative, digit2..0.
module signed_bin_to_bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] val_in,
  output logic             busy,
  output logic             done,
  output logic             is_negative,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mag;
  logic [11:0]      bcd;
  logic [3:0]       cnt;
  logic             sign;

  logic [WIDTH-1:0] neg_val;
  logic [11:0]      adj;
  logic [WIDTH+11:0] sh;
  logic [11:0]      bcd_nx;
  logic [WIDTH-1:0] mag_nx;
  logic             last;

  // -2^(WIDTH-1) negates to itself, which is the right unsigned magnitude
  assign neg_val = ~val_in + 1'b1;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign sh     = {adj, mag} << 1;
  assign bcd_nx = sh[WIDTH+11:WIDTH];
  assign mag_nx = sh[WIDTH-1:0];
  assign last   = (cnt == 4'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      is_negative <= 1'b0;
      digit2      <= 4'd0;
      digit1      <= 4'd0;
      digit0      <= 4'd0;
      mag         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign  <= val_in[WIDTH-1];
            mag   <= val_in[WIDTH-1] ? neg_val : val_in;
            bcd   <= '0;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          bcd <= bcd_nx;
          mag <= mag_nx;
          cnt <= cnt + 4'd1;
          // outputs take the final shifted value directly, so the
          // partial accumulator is never visible
          if (last) begin
            state       <= DONE;
            done        <= 1'b1;
            is_negative <= sign;
            digit2      <= bcd_nx[11:8];
            digit1      <= bcd_nx[7:4];
            digit0      <= bcd_nx[3:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bin_to_bcd_seq.sv
// Testbench for signed_bin_to_bcd_seq: WIDTH=8 and WIDTH=9 instances,
// scoreboard queues of expected {neg,d2,d1,d0}.
module tb_signed_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, busy_a, done_a, neg_a;
  logic [7:0] val_a;
  logic [3:0] d2a, d1a, d0a;

  logic       rst_b, start_b, busy_b, done_b, neg_b;
  logic [8:0] val_b;
  logic [3:0] d2b, d1b, d0b;

  signed_bin_to_bcd_seq #(.WIDTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .val_in(val_a),
    .busy(busy_a), .done(done_a), .is_negative(neg_a),
    .digit2(d2a), .digit1(d1a), .digit0(d0a)
  );

  signed_bin_to_bcd_seq #(.WIDTH(9)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .val_in(val_b),
    .busy(busy_b), .done(done_b), .is_negative(neg_b),
    .digit2(d2b), .digit1(d1b), .digit0(d0b)
  );

  int checks = 0;
  int failures = 0;
  logic [12:0] q_a[$];
  logic [12:0] q_b[$];

  wire [12:0] out_a = {neg_a, d2a, d1a, d0a};
  wire [12:0] out_b = {neg_b, d2b, d1b, d0b};

  function automatic logic [12:0] model(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic pulse_a(input logic [7:0] v, input bit push);
    @(negedge clk);
    start_a = 1'b1;
    val_a = v;
    if (push) q_a.push_back(model(int'($signed(v))));
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [8:0] v, input bit push);
    @(negedge clk);
    start_b = 1'b1;
    val_b = v;
    if (push) q_b.push_back(model(int'($signed(v))));
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(output bit got, output int cyc);
    got = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done_a) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_done_b(output bit got, output int cyc);
    got = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done_b) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b0; start_a = 1'b0; val_a = '0;
    rst_b = 1'b0; start_b = 1'b0; val_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, done_a, out_a} !== 15'd0) begin
      failures++;
      $display("FAIL reset_a got=%0h exp=0", {busy_a, done_a, out_a});
    end
    checks++;
    if ({busy_b, done_b, out_b} !== 15'd0) begin
      failures++;
      $display("FAIL reset_b got=%0h exp=0", {busy_b, done_b, out_b});
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic test_basic;
    int bcnt;
    int lat;
    logic [12:0] e;
    bit got;
    pulse_a(8'd123, 1);
    bcnt = 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) bcnt++;
      if (done_a) begin
        got = 1;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL basic_done got=timeout exp=done");
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=8", lat);
    end
    checks++;
    if (bcnt != 9) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d exp=9", bcnt);
    end
    e = q_a.pop_front();
    checks++;
    if (out_a !== e) begin
      failures++;
      $display("FAIL basic_result got=%0h exp=%0h", out_a, e);
    end
    @(negedge clk);
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after got=%0b exp=00", {busy_a, done_a});
    end
  endtask

  task automatic test_negative;
    logic [7:0] vals[3] = '{8'h80, 8'hFF, 8'h00};
    logic [12:0] e;
    bit got;
    int cyc;
    foreach (vals[k]) begin
      pulse_a(vals[k], 1);
      wait_done_a(got, cyc);
      e = q_a.pop_front();
      checks++;
      if (!got || out_a !== e) begin
        failures++;
        $display("FAIL neg_%0h got=%0h done=%0b exp=%0h", vals[k], out_a, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    logic [12:0] prev;
    logic [12:0] e;
    int dcnt;
    bit held;
    prev = out_a;
    pulse_a(8'd127, 1);
    held = 1;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) begin
        start_a = 1'b1;
        val_a = 8'd45;
      end
      if (i == 3) start_a = 1'b0;
      if (done_a) begin
        dcnt++;
        e = q_a.pop_front();
        checks++;
        if (out_a !== e) begin
          failures++;
          $display("FAIL ignore_result got=%0h exp=%0h", out_a, e);
        end
      end else if (dcnt == 0 && out_a !== prev) begin
        held = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL ignore_hold got=changed exp=%0h", prev);
    end
    checks++;
    if (dcnt != 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d exp=1", dcnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [12:0] e;
    bit got;
    int cyc;
    @(negedge clk);
    start_a = 1'b1;
    val_a = 8'd99;
    for (int k = 0; k < 3; k++) q_a.push_back(model(99));
    for (int k = 0; k < 3; k++) begin
      wait_done_a(got, cyc);
      if (k == 2) start_a = 1'b0;
      e = q_a.pop_front();
      checks++;
      if (!got || out_a !== e) begin
        failures++;
        $display("FAIL b2b_result_%0d got=%0h exp=%0h", k, out_a, e);
      end
      checks++;
      if (cyc != 9) begin
        failures++;
        $display("FAIL b2b_interval_%0d got=%0d exp=9", k, cyc);
      end
      @(negedge clk);
      checks++;
      if ({busy_a, done_a} !== 2'b00) begin
        failures++;
        $display("FAIL b2b_idle_%0d got=%0b exp=00", k, {busy_a, done_a});
      end
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop got=%0b exp=0", busy_a);
    end
  endtask

  task automatic test_reset_abort;
    logic [12:0] e;
    bit got;
    int cyc;
    int dcnt;
    pulse_b(-9'sd37, 1);
    wait_done_b(got, cyc);
    e = q_b.pop_front();
    checks++;
    if (!got || out_b !== e || cyc != 9) begin
      failures++;
      $display("FAIL abort_prior got=%0h cyc=%0d exp=%0h cyc=9", out_b, cyc, e);
    end
    @(negedge clk);
    pulse_b(9'd200, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    checks++;
    if ({busy_b, done_b, out_b} !== 15'd0) begin
      failures++;
      $display("FAIL abort_clear got=%0h exp=0", {busy_b, done_b, out_b});
    end
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_b) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", dcnt);
    end
    pulse_b(9'h1F6, 1);
    wait_done_b(got, cyc);
    e = q_b.pop_front();
    checks++;
    if (!got || out_b !== e) begin
      failures++;
      $display("FAIL abort_new got=%0h exp=%0h", out_b, e);
    end
    checks++;
    if (cyc != 9) begin
      failures++;
      $display("FAIL abort_latency got=%0d exp=9", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
